core_seq: RTL

Multi-cycle sequencer for the non-pipelined core. It steps each instruction through fetch, decode/execute, optional memory or multiply/divide wait, and writeback. It drives the fetch and load/store handshakes and the multi-cycle MUL/DIV start strobe. It gates the register-file, CSR and PC write enables. The instruction decoder is combinational; `core_seq` consumes its control outputs and decides when they take effect.

---
 rtl/core_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/core_seq.sv
// core_seq: multi-cycle sequencer for the non-pipelined core.
//
// Steps each instruction through fetch, execute, an optional LSU or MUL/DIV
// wait, and writeback. It drives the IFU/LSU request handshakes and the
// MUL/DIV start strobe, and gates the RF/CSR/PC write enables.
//
// State table:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   BOOT    | post-reset settle, BOOT_CYC cycles, every input ignored
//   FETCH   | ifu_req_valid high until ifu_req_ready
//   IWAIT   | wait for ifu_rsp_valid; inst_load on that cycle
//   EXEC    | branch on decode (ebreak > mem > mul/div > alu)
//   MREQ    | lsu_req_valid high until lsu_req_ready
//   MWAIT   | wait for lsu_rsp_valid
//   MDWAIT  | wait for md_done (md_start was issued once, in EXEC)
//   WB      | single cycle: pc/rf/csr/trap enables, instret += 1
//   HALT    | stopped by ebreak; sticky until reset
//
// Ports:
//   clk, rst_b                        clock, async active-low reset
//   ifu_req_valid/ready, ifu_rsp_valid, inst_load    fetch side
//   dec_*                             decoder controls (used in EXEC and WB)
//   lsu_req_valid/ready, lsu_rsp_valid               load/store side
//   md_start, md_done                 MUL/DIV handshake
//   rf_wen, csr_wen, pc_wen, trap_en  writeback enables
//   halted                            HALT indicator
//   instret                           retired-instruction counter (wraps)

module core_seq #(
    parameter int BOOT_CYC = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_rsp_valid,
    output logic             inst_load,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_mul,
    input  logic             dec_div,
    input  logic             dec_ebreak,
    input  logic             dec_ecall,
    input  logic             dec_mret,
    input  logic             dec_rd_write,
    input  logic             dec_csr_write,
    input  logic             dec_csr_set,
    input  logic             dec_csr_clear,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    output logic             md_start,
    input  logic             md_done,
    output logic             rf_wen,
    output logic             csr_wen,
    output logic             pc_wen,
    output logic             trap_en,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYC - 1);

    typedef enum logic [3:0] {
        S_BOOT   = 4'd0,
        S_FETCH  = 4'd1,
        S_IWAIT  = 4'd2,
        S_EXEC   = 4'd3,
        S_MREQ   = 4'd4,
        S_MWAIT  = 4'd5,
        S_MDWAIT = 4'd6,
        S_WB     = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            instret_q  <= instret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        instret_d     = instret_q;
        ifu_req_valid = 1'b0;
        inst_load     = 1'b0;
        lsu_req_valid = 1'b0;
        md_start      = 1'b0;
        rf_wen        = 1'b0;
        csr_wen       = 1'b0;
        pc_wen        = 1'b0;
        trap_en       = 1'b0;
        halted        = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            S_FETCH: begin
                ifu_req_valid = 1'b1;
                // a response coincident with acceptance is not honoured
                if (ifu_req_ready) begin
                    state_d = S_IWAIT;
                end
            end
            S_IWAIT: begin
                if (ifu_rsp_valid) begin
                    inst_load = 1'b1;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_ebreak) begin
                    state_d = S_HALT;
                end else if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MREQ;
                end else if (dec_mul || dec_div) begin
                    md_start = 1'b1;
                    state_d  = S_MDWAIT;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MREQ: begin
                lsu_req_valid = 1'b1;
                if (lsu_req_ready) begin
                    state_d = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (lsu_rsp_valid) begin
                    state_d = S_WB;
                end
            end
            S_MDWAIT: begin
                if (md_done) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_wen    = 1'b1;
                rf_wen    = dec_rd_write;
                csr_wen   = dec_csr_write | dec_csr_set | dec_csr_clear;
                trap_en   = dec_ecall | dec_mret;
                instret_d = instret_q + 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign instret = instret_q;

endmodule
